mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between three requesters:
  - decompressor (read, ID 0)
  - weight buffer (read, ID 1)
  - compressor (write, ID 2)
- Round-robin arbitration, one grant per cycle.
- Keeps one auto-incrementing address counter per requester.
- Tracks in-flight reads in a source-tag FIFO so that in-order read returns reach the correct consumer.
- Sits between the layer controller / datapath clients and the testbench memory model.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 256, memory data width (MEM_BANDWIDTH*8).
- TAG_DEPTH, 16, max outstanding reads; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  sync flush/reload pulse (layer start)
- rd0_base  in  ADDR_W  decompressor start address, loaded on clear
- rd1_base  in  ADDR_W  weight buffer start address, loaded on clear
- wr_base  in  ADDR_W  compressor start address, loaded on clear
- req  in  3  request level: [0] decompressor, [1] weight buffer, [2] compressor
- wr_data  in  DATA_W  compressor write data, valid with req[2]
- gnt  out  3  one-hot-or-zero grant, combinational
- mem_addr  out  ADDR_W  registered issue address
- mem_read_valid  out  1  registered read strobe
- mem_write_valid  out  1  registered write strobe
- mem_write_data  out  DATA_W  registered write data
- mem_rd_data  in  DATA_W  read return data
- mem_rd_valid  in  1  read return strobe; returns are in order
- rd_data  out  DATA_W  mem_rd_data passthrough
- rd_valid  out  2  routed return valid: [0] decompressor, [1] weight buffer
- outstanding  out  $clog2(TAG_DEPTH)+1  in-flight read count
- err  out  1  sticky: return arrived with no tag outstanding

Behaviour:
- Reset: all outputs 0, all address counters 0, RR pointer = 0, tag FIFO empty, err = 0.
- clear (synchronous, overrides everything else in its cycle):
  - gnt forced 0.
  - Counters loaded from *_base.
  - Tag FIFO flushed; outstanding = 0; RR pointer = 0.
  - err NOT cleared (only rst_n clears it).
- Eligibility:
  - req[0], req[1] eligible only when tag FIFO not full, based on the registered count. No bypass: a pop in the same cycle does not unblock.
  - req[2] always eligible.
- Arbitration:
  - Search eligible requests starting at the RR pointer, wrapping 0→1→2→0.
  - First hit is granted.
  - On a grant to i, pointer <= (i+1) mod 3; with no grant, pointer holds.
- Grant cycle effects for requester i (registered, visible next cycle):
  - mem_addr <= addr_i.
  - mem_read_valid <= (i<2); mem_write_valid <= (i==2); mem_write_data <= wr_data when i==2.
  - addr_i <= addr_i + 1, wrapping modulo 2^ADDR_W.
  - Read grant pushes tag i.
- No-grant cycle: mem_read_valid and mem_write_valid go 0; mem_addr and mem_write_data hold.
- Issue latency: req high with gnt in cycle N → mem strobe in cycle N+1. Requester holds req as a level and sees one grant per transfer.
- Return path (combinational, zero latency):
  - On mem_rd_valid with FIFO non-empty: rd_valid[head_tag] = 1 and pop.
  - On mem_rd_valid with FIFO empty: rd_valid = 0, err <= 1, nothing popped.
- Simultaneous push and pop: occupancy unchanged; head and tail pointers both advance.
- outstanding = FIFO occupancy, range 0..TAG_DEPTH.
- Reset mid-operation: everything returns to reset values; returns after the reset are treated as orphans and set err.

Test Plan:
- Single read: clear with rd0_base=0x100, hold req=3'b001 for 3 cycles.
  - Response: gnt[0] each cycle; mem_addr 0x100, 0x101, 0x102 with mem_read_valid in cycles 1–3; outstanding reaches 3.
  - Then 3 mem_rd_valid pulses → rd_valid=2'b01 each; outstanding=0.
- Round-robin fairness: req=3'b111 held for 6 cycles → grant order 0,1,2,0,1,2; mem_write_valid only in the 3rd and 6th issue cycles; wr addresses wr_base, wr_base+1.
- Interleaved returns: grants 0,1,1,0 then 4 returns → rd_valid sequence 01,10,10,01.
- Full tag FIFO: 16 reads outstanding, req=3'b011 → gnt=0.
  - With req=3'b111 → gnt=3'b100.
  - A return pop in the same cycle still gives gnt[0]=0; the read is granted next cycle.
- Orphan return and clear:
  - mem_rd_valid with FIFO empty → err=1, rd_valid=0.
  - clear with 5 outstanding → outstanding=0, counters = new bases, err stays 1.
- Wrap: rd1_base=0xFFFFFFFF, two grants to ID 1 → mem_addr 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two read clients and one write client.
// In-flight reads are tagged in a FIFO so in-order returns are routed back to their issuer.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [ADDR_W-1:0]            rd0_base,
  input  logic [ADDR_W-1:0]            rd1_base,
  input  logic [ADDR_W-1:0]            wr_base,
  input  logic [2:0]                   req,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [2:0]                   gnt,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_read_valid,
  output logic                         mem_write_valid,
  output logic [DATA_W-1:0]            mem_write_data,
  input  logic [DATA_W-1:0]            mem_rd_data,
  input  logic                         mem_rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic [1:0]                   rd_valid,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_reg [3];
  logic [ADDR_W-1:0] base_val [3];
  logic [1:0]        rr_reg, rr_next;
  logic              tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [2:0]        eligible;
  logic [2:0]        sum, idx;
  logic              hit, full, empty, push, pop, orphan;
  logic [ADDR_W-1:0] issue_addr;

  assign base_val[0] = rd0_base;
  assign base_val[1] = rd1_base;
  assign base_val[2] = wr_base;

  // Read eligibility looks only at the registered count; a same-cycle pop does not free a slot.
  assign full     = (count_reg == CNT_W'(TAG_DEPTH));
  assign empty    = (count_reg == '0);
  assign eligible = req & {1'b1, ~full, ~full};

  always_comb begin
    gnt     = '0;
    rr_next = rr_reg;
    hit     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < 3; k++) begin
      sum = 3'(rr_reg) + 3'(k);
      idx = (sum >= 3'd3) ? (sum - 3'd3) : sum;
      if (!hit && !clear && eligible[idx[1:0]]) begin
        hit              = 1'b1;
        gnt[idx[1:0]]    = 1'b1;
        rr_next          = (idx == 3'd2) ? 2'd0 : (idx[1:0] + 2'd1);
      end
    end
  end

  always_comb begin
    if (gnt[0])      issue_addr = addr_reg[0];
    else if (gnt[1]) issue_addr = addr_reg[1];
    else             issue_addr = addr_reg[2];
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_addr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          addr_reg[gi] <= '0;
        else if (clear)      addr_reg[gi] <= base_val[gi];
        else if (gnt[gi])    addr_reg[gi] <= addr_reg[gi] + ADDR_W'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg          <= '0;
      mem_addr        <= '0;
      mem_read_valid  <= 1'b0;
      mem_write_valid <= 1'b0;
      mem_write_data  <= '0;
    end else begin
      rr_reg          <= clear ? 2'd0 : rr_next;
      mem_read_valid  <= |gnt[1:0];
      mem_write_valid <= gnt[2];
      if (|gnt)  mem_addr       <= issue_addr;
      if (gnt[2]) mem_write_data <= wr_data;
    end
  end

  assign push   = |gnt[1:0];
  assign pop    = mem_rd_valid && !empty;
  assign orphan = mem_rd_valid && empty;

  // Tag entry is 1 for the weight buffer, 0 for the decompressor.
  always_ff @(posedge clk) begin
    if (push) tag_mem[tail_reg] <= gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky until rst_n: a layer-start clear must not hide an earlier protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err <= 1'b0;
    else if (orphan) err <= 1'b1;
  end

  assign rd_data     = mem_rd_data;
  assign rd_valid    = pop ? (tag_mem[head_reg] ? 2'b10 : 2'b01) : 2'b00;
  assign outstanding = count_reg;

endmodule
